// File: rtl/reg_file.sv
// 32 x 32-bit register file with two combinational read ports and one write port.
// Register 0 is hard-wired to zero; registers 1-31 are individual register instances.

module register (
  input  logic        clock,
  input  logic        write_enable,
  input  logic [31:0] d,
  output logic [31:0] q,
  input  logic        reset_n
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (write_enable) begin
      q <= d;
    end
  end

endmodule

module reg_file (
  input  logic        clock,
  input  logic [4:0]  read_id_1,
  input  logic [4:0]  read_id_2,
  input  logic        write_enable,
  input  logic [4:0]  write_id,
  input  logic [31:0] write_val,
  output logic [31:0] read_val_1,
  output logic [31:0] read_val_2,
  input  logic        reset_n
);

  logic [31:0] regs [32];
  logic [31:0] reg_we;

  assign regs[0]   = '0;
  assign reg_we[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_reg
      // Decoded per-register enable; index 0 never matches, so writes to it vanish.
      assign reg_we[gi] = write_enable && (write_id == 5'(gi));

      register u_register (
        .clock        (clock),
        .write_enable (reg_we[gi]),
        .d            (write_val),
        .q            (regs[gi]),
        .reset_n      (reset_n)
      );
    end
  endgenerate

  assign read_val_1 = regs[read_id_1];
  assign read_val_2 = regs[read_id_2];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, hand-written edge/reset
// sequences, then randomized traffic against an array-based reference model.

module tb_reg_file;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  read_id_1, read_id_2, write_id;
  logic        write_enable;
  logic [31:0] write_val;
  logic [31:0] read_val_1, read_val_2;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] model [32];

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  wid;
    logic [31:0] wval;
    logic [4:0]  rid1;
    logic [4:0]  rid2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [10];

  always #5 clock = ~clock;

  reg_file dut (
    .clock        (clock),
    .read_id_1    (read_id_1),
    .read_id_2    (read_id_2),
    .write_enable (write_enable),
    .write_id     (write_id),
    .write_val    (write_val),
    .read_val_1   (read_val_1),
    .read_val_2   (read_val_2),
    .reset_n      (reset_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic [4:0] wid,
                              input logic [31:0] wval, input logic [4:0] rid1,
                              input logic [4:0] rid2, input logic [31:0] exp1,
                              input logic [31:0] exp2);
    vec_t v;
    v.name = name; v.we = we; v.wid = wid; v.wval = wval;
    v.rid1 = rid1; v.rid2 = rid2; v.exp1 = exp1; v.exp2 = exp2;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v);
    @(negedge clock);
    write_enable = v.we; write_id = v.wid; write_val = v.wval;
    read_id_1 = v.rid1; read_id_2 = v.rid2;
    @(posedge clock);
    #1;
    check({v.name, "_p1"}, read_val_1, v.exp1);
    check({v.name, "_p2"}, read_val_2, v.exp2);
    $display("vec %-12s we=%0d wid=%0d wval=%h -> r1=%h r2=%h", v.name, v.we, v.wid,
             v.wval, read_val_1, read_val_2);
  endtask

  initial begin
    vecs[0] = mk("wr_dis_a",  1'b0, 5'd1, 32'd5,        5'd1, 5'd2, 32'd0,  32'd0);
    vecs[1] = mk("wr_dis_b",  1'b0, 5'd1, 32'd5,        5'd1, 5'd2, 32'd0,  32'd0);
    vecs[2] = mk("basic",     1'b1, 5'd1, 32'd5,        5'd1, 5'd2, 32'd5,  32'd0);
    vecs[3] = mk("pre_edge",  1'b0, 5'd1, 32'd30,       5'd1, 5'd2, 32'd5,  32'd0);
    vecs[4] = mk("seq_r1",    1'b1, 5'd1, 32'd10,       5'd1, 5'd2, 32'd10, 32'd29);
    vecs[5] = mk("hold_a",    1'b0, 5'd1, 32'd7,        5'd1, 5'd2, 32'd10, 32'd29);
    vecs[6] = mk("hold_b",    1'b0, 5'd1, 32'd7,        5'd1, 5'd2, 32'd10, 32'd29);
    vecs[7] = mk("r0_write",  1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'd0,  32'd0);
    vecs[8] = mk("same_r1",   1'b0, 5'd0, 32'd0,        5'd1, 5'd1, 32'd10, 32'd10);
    vecs[9] = mk("same_r2",   1'b0, 5'd0, 32'd0,        5'd2, 5'd2, 32'd29, 32'd29);

    reset_n = 1'b0;
    write_enable = 1'b0; write_id = '0; write_val = '0;
    read_id_1 = 5'd1; read_id_2 = 5'd2;
    #1;
    check("reset_r1", read_val_1, 32'd0);
    check("reset_r2", read_val_2, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) apply_vec(vecs[i]);

    // Inputs changed while clock is high must wait for the next rising edge.
    write_enable = 1'b1; write_val = 32'd29; write_id = 5'd2;
    #1;
    check("hi_no_change", read_val_2, 32'd0);
    @(negedge clock); #1;
    check("lo_no_change", read_val_2, 32'd0);
    @(posedge clock); #1;
    check("edge_r2", read_val_2, 32'd29);
    check("edge_r1", read_val_1, 32'd5);
    write_val = 32'd4;
    #1;
    check("hi_ignored", read_val_2, 32'd29);
    $display("seq sample_at_edge r1=%h r2=%h", read_val_1, read_val_2);

    for (int i = 4; i < 10; i++) apply_vec(vecs[i]);

    // Async reset between edges, then a blocked write during reset.
    @(negedge clock);
    write_enable = 1'b0; read_id_1 = 5'd1; read_id_2 = 5'd2;
    #1;
    check("pre_rst_r1", read_val_1, 32'd10);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_r1", read_val_1, 32'd0);
    check("arst_r2", read_val_2, 32'd0);
    write_enable = 1'b1; write_id = 5'd1; write_val = 32'd55;
    @(posedge clock); #1;
    check("rst_blk_r1", read_val_1, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("post_rst_r1", read_val_1, 32'd0);
    @(posedge clock); #1;
    check("first_edge_wr", read_val_1, 32'd55);
    check("first_edge_r2", read_val_2, 32'd0);
    $display("seq async_reset r1=%h r2=%h", read_val_1, read_val_2);

    for (int i = 0; i < 32; i++) model[i] = '0;
    model[1] = 32'd55;

    for (int n = 0; n < 400; n++) begin
      logic        we;
      logic [4:0]  wid;
      logic [31:0] wval;
      @(negedge clock);
      we = 1'($urandom_range(0, 1));
      wid = 5'($urandom_range(0, 31));
      wval = $urandom;
      write_enable = we; write_id = wid; write_val = wval;
      read_id_1 = 5'($urandom_range(0, 31));
      read_id_2 = ($urandom_range(0, 3) == 0) ? read_id_1 : 5'($urandom_range(0, 31));
      #1;
      check("rnd_pre_r1", read_val_1, model[read_id_1]);
      check("rnd_pre_r2", read_val_2, model[read_id_2]);
      if ($urandom_range(0, 39) == 0) begin
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        check("rnd_arst_r1", read_val_1, 32'd0);
        check("rnd_arst_r2", read_val_2, 32'd0);
        #1;
        reset_n = 1'b1;
      end
      @(posedge clock);
      if (we && wid != 5'd0) model[wid] = wval;
      #1;
      check("rnd_post_r1", read_val_1, model[read_id_1]);
      check("rnd_post_r2", read_val_2, model[read_id_2]);
      $display("rnd %0d we=%0d wid=%0d wval=%h rid=%0d/%0d -> %h/%h", n, we, wid, wval,
               read_id_1, read_id_2, read_val_1, read_val_2);
      // Junk on the write inputs while clock is high must not be captured.
      write_enable = 1'($urandom_range(0, 1));
      write_id = 5'($urandom_range(0, 31));
      write_val = $urandom;
      #1;
      check("rnd_hi_r1", read_val_1, model[read_id_1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port list:
- clock  input  1  system clock; all state updates occur on its rising edge.
- reset_n  input  1  asynchronous reset, active low.
- read_id_1  input  5  register index for read port 1.
- read_id_2  input  5  register index for read port 2.
- write_enable  input  1  high = write write_val into write_id at next rising edge.
- write_id  input  5  register index for the write port.
- write_val  input  32  data to write.
- read_val_1  output  32  contents of register read_id_1.
- read_val_2  output  32  contents of register read_id_2.
REQ-003 Port order at instantiation SHALL be: clock, read_id_1, read_id_2, write_enable, write_id, write_val, read_val_1, read_val_2, reset_n.
REQ-004 Storage SHALL be 32 registers x 32 bits, indices 0-31.
REQ-005 Registers 1-31 SHALL each be built from a companion module "register".
- register ports: clock, write_enable, d[31:0], q[31:0], reset_n.
- q loads d on the rising clock edge when write_enable is 1, otherwise it holds.
- q clears to 0 asynchronously while reset_n is 0.

Function
REQ-006 A write SHALL occur only on a rising clock edge, and only when write_enable=1 and write_id!=0.
- Only register write_id SHALL change.
- All other registers SHALL hold.
REQ-007 write_enable, write_id and write_val SHALL be sampled only at the rising edge. Changes between edges SHALL NOT affect stored state or outputs.
REQ-008 Reads SHALL be combinational.
- read_val_1 SHALL equal reg[read_id_1] continuously.
- read_val_2 SHALL equal reg[read_id_2] continuously.
- Both outputs update in the same delta after a write edge. Nonblocking update semantics SHALL be used so that both ports stay mutually consistent.
REQ-009 Write-to-read latency SHALL be one edge. A read of the register being written returns the old value before the edge and the new value after it. There is no write-through bypass.
REQ-010 Register 0 SHALL always read 0. Writes to index 0 SHALL be ignored.
REQ-011 Both read ports SHALL be able to address the same register simultaneously, including the register being written, and both SHALL return identical values.
REQ-012 Outputs SHALL never be X/Z once reset has been applied.

Reset
REQ-013 While reset_n=0:
- all 32 registers SHALL be 0, immediately and asynchronously, independent of clock;
- both outputs SHALL read 0;
- writes SHALL be blocked.
REQ-014 Reset asserted mid-operation SHALL discard any write pending for the next edge.
REQ-015 After reset_n rises, the first rising clock edge SHALL perform a normal write if write_enable=1.

Verification
REQ-016 Bench SHALL cover these directed scenarios (read_id_1=1, read_id_2=2 unless stated):
- Write disabled: after reset, write_id=1, write_val=5, write_enable=0, two edges -> read_val_1=0, read_val_2=0.
- Basic write: write_enable=1, write_id=1, write_val=5, rising edge -> read_val_1=5; read_val_2 stays 0.
- Sampling only at the edge:
  - Before the edge: write_val=30 with write_enable=0 -> no change.
  - While clock high: set write_enable=1, write_val=29, write_id=2 -> no change until the next rising edge.
  - At that next rising edge -> read_val_2=29, read_val_1 still 5.
  - While clock high: set write_val=4 -> ignored.
- Sequential writes:
  - Set write_id=1, write_val=10 before the edge -> read_val_1=10 after the edge.
  - Then write_enable=0, write_val=7 -> outputs stay 10 / 29 over further edges.
- Register 0:
  - write_id=0, write_val=0xFFFFFFFF, write_enable=1, edge; read_id_1=0 -> read_val_1=0.
  - Both ports reading the same index return equal values.
- Async reset:
  - With r1=10 and r2=29, pulse reset_n low between edges -> both outputs go to 0 immediately.
  - An edge during reset with write_enable=1 -> no write.
